// File: rtl/product_serializer.sv
// Wide-product serializer: captures one WIDTH-bit product and streams it out
// as NW words of WORD bits, least-significant word first, with valid/ready handshakes.
module product_serializer #(
    parameter int WIDTH = 768,
    parameter int WORD  = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WORD-1:0]  out_data,
    output logic             out_last,
    input  logic             out_ready,
    output logic             busy
);

    localparam int NW = WIDTH / WORD;
    localparam int CW = (NW > 1) ? $clog2(NW) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(NW - 1);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] buffer, buffer_nxt;
    logic [CW-1:0]    count, count_nxt;

    // NOTE: the product buffer is reset too, so out_data reads zero while rst is low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            buffer <= '0;
            count  <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register updating from pre-edge values.
            state  <= state_nxt;
            buffer <= buffer_nxt;
            count  <= count_nxt;
        end
    end

    // NOTE: hold values are assigned first so no path through this block infers a latch.
    always_comb begin
        state_nxt  = state;
        buffer_nxt = buffer;
        count_nxt  = count;
        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    buffer_nxt = in_data;
                    count_nxt  = '0;
                    state_nxt  = SEND;
                end
            end
            SEND: begin
                if (out_ready) begin
                    buffer_nxt = buffer >> WORD;
                    if (count == LAST_IDX) begin
                        // Counter wraps to 0 rather than passing NW-1.
                        count_nxt = '0;
                        state_nxt = IDLE;
                    end else begin
                        count_nxt = count + 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs decode registered state only; nothing depends on out_ready or in_valid.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == SEND);
    assign busy      = (state == SEND);
    assign out_last  = (state == SEND) && (count == LAST_IDX);
    assign out_data  = buffer[WORD-1:0];

endmodule

// File: tb/tb_product_serializer.sv
// Scoreboard bench for product_serializer: expected words are queued at capture
// and popped on every out_valid/out_ready transfer.
module tb_product_serializer;

    localparam int WIDTH = 768;
    localparam int WORD  = 64;
    localparam int NW    = WIDTH / WORD;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [WORD-1:0]  out_data;
    logic             out_last;
    logic             out_ready;
    logic             busy;

    product_serializer #(.WIDTH(WIDTH), .WORD(WORD)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_last (out_last),
        .out_ready(out_ready),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [WORD-1:0] data;
        logic            last;
    } exp_t;

    exp_t sb[$];

    int n_tests;
    int n_fail;
    int n_words;

    // Per-step samples, taken #1 after the falling edge.
    logic            s_valid, s_busy, s_rdy, s_cap, s_xfer;
    logic            prev_stall;
    logic [WORD-1:0] prev_data;
    logic            prev_last;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_product(input logic [WIDTH-1:0] d);
        exp_t e;
        for (int k = 0; k < NW; k++) begin
            e.data = d[k*WORD +: WORD];
            e.last = (k == NW - 1);
            sb.push_back(e);
        end
    endtask

    // Drive inputs for the coming rising edge, then score what that edge will do.
    task automatic step(input logic iv, input logic [WIDTH-1:0] id, input logic ordy);
        exp_t e;
        @(negedge clk);
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        #1;
        s_valid = out_valid;
        s_busy  = busy;
        s_rdy   = in_ready;
        s_cap   = in_ready && iv;
        s_xfer  = out_valid && ordy;
        if (prev_stall && out_valid) begin
            check("hold_data", out_data, prev_data);
            check("hold_last", 64'(out_last), 64'(prev_last));
        end
        if (s_xfer) begin
            check("word_expected", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("word", out_data, e.data);
                check("last", 64'(out_last), 64'(e.last));
            end
            n_words++;
        end
        prev_stall = out_valid && !ordy;
        prev_data  = out_data;
        prev_last  = out_last;
        if (s_cap) push_product(id);
    endtask

    task automatic capture(input logic [WIDTH-1:0] d);
        int  n;
        logic cap;
        n   = 0;
        cap = 1'b0;
        while (!cap && n < 50) begin
            step(1'b1, d, 1'b1);
            cap = s_cap;
            n++;
        end
        check("captured", 64'(cap), 64'd1);
    endtask

    task automatic send_product(input logic [WIDTH-1:0] d, input logic toggle,
                                input logic noise, output int busy_cycles);
        int   n;
        logic ph;
        logic first;
        capture(d);
        busy_cycles = 0;
        ph    = 1'b1;
        first = 1'b1;
        n     = 0;
        while (sb.size() > 0 && n < 400) begin
            step(noise, ~d, toggle ? ph : 1'b1);
            if (first) check("first_word_latency", 64'(s_valid), 64'd1);
            first = 1'b0;
            if (s_busy) busy_cycles++;
            ph = ~ph;
            n++;
        end
        check("drain_done", 64'(sb.size()), 64'd0);
        step(1'b0, '0, 1'b1);
        check("idle_in_ready", 64'(s_rdy), 64'd1);
        check("idle_out_valid", 64'(s_valid), 64'd0);
    endtask

    initial begin
        logic [WIDTH-1:0] pat_a, pat_b, ones;
        int bc, n, gap, caps, vcount;

        n_tests    = 0;
        n_fail     = 0;
        n_words    = 0;
        prev_stall = 1'b0;
        prev_data  = '0;
        prev_last  = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        out_ready  = 1'b0;
        for (int k = 0; k < NW; k++) begin
            pat_a[k*WORD +: WORD] = 64'(k + 1);
            pat_b[k*WORD +: WORD] = 64'(k + 16'h100);
        end
        ones = '1;

        // Reset state
        rst = 1'b0;
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_out_last", 64'(out_last), 64'd0);
        check("rst_out_data", out_data, 64'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;

        // Single-bit product, out_ready held high
        send_product(WIDTH'(1), 1'b0, 1'b0, bc);
        check("busy_cycles_one", 64'(bc), 64'(NW));

        // All-ones product
        send_product(ones, 1'b0, 1'b0, bc);
        check("busy_cycles_ones", 64'(bc), 64'(NW));

        // Counting words with out_ready toggling 1,0,1,0
        send_product(pat_a, 1'b1, 1'b0, bc);

        // Competing in_valid during SEND must be ignored
        send_product(pat_b, 1'b0, 1'b1, bc);

        // Asynchronous reset after the 5th transfer
        capture(pat_a);
        n_words = 0;
        n = 0;
        while (n_words < 5 && n < 50) begin
            step(1'b0, '0, 1'b1);
            n++;
        end
        check("five_words", 64'(n_words), 64'd5);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("arst_out_valid", 64'(out_valid), 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_in_ready", 64'(in_ready), 64'd1);
        check("arst_out_last", 64'(out_last), 64'd0);
        check("arst_out_data", out_data, 64'd0);
        sb.delete();
        prev_stall = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        vcount = 0;
        repeat (20) begin
            step(1'b0, '0, 1'b1);
            if (s_valid) vcount++;
        end
        check("post_rst_silent", 64'(vcount), 64'd0);

        // Two products back-to-back: exactly one idle cycle between them
        n_words = 0;
        gap  = 0;
        caps = 0;
        n    = 0;
        while (!(caps == 2 && sb.size() == 0) && n < 200) begin
            step(caps < 2, (caps == 0) ? pat_a : pat_b, 1'b1);
            if (!s_valid && n_words == NW) gap++;
            if (s_cap) caps++;
            n++;
        end
        check("b2b_words", 64'(n_words), 64'(2 * NW));
        check("b2b_gap", 64'(gap), 64'd1);

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
